// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the I/D memory port arbiter: FSM states, owner codes, abort data.
// The optional busy timeout is enabled with the MEM_ARB_TIMEOUT_EN macro.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusyI = 2'd1,
    StBusyD = 2'd2
  } arb_state_e;

  typedef enum logic {
    OwnerI = 1'b0,
    OwnerD = 1'b1
  } owner_e;

  // Read data returned to the owner when a transaction is aborted.
  localparam int unsigned RdataErr = 0;

  function automatic owner_e state_owner(arb_state_e s);
    return (s == StBusyD) ? OwnerD : OwnerI;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and unified memory port seen by the arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/memory view.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();

  logic            i_req;
  logic [AW-1:0]   i_addr;
  logic            i_gnt;
  logic            i_rvalid;
  logic [DW-1:0]   i_rdata;

  logic            d_req;
  logic            d_we;
  logic [DW/8-1:0] d_be;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic            d_gnt;
  logic            d_rvalid;
  logic [DW-1:0]   d_rdata;

  logic            mem_req;
  logic            mem_we;
  logic [DW/8-1:0] mem_be;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_ack;
  logic [DW-1:0]   mem_rdata;

  logic            err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ack, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata, err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ack, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata, err
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (I) and load/store (D).
// Define MEM_ARB_TIMEOUT_EN to abort transactions that see no mem_ack within TIMEOUT cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 3
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT    = 16
`endif
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
`endif

  arb_state_e    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
  logic          i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [BW-1:0] mem_be_q, mem_be_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          err_q, err_d;
  logic          i_turn;
`ifdef MEM_ARB_TIMEOUT_EN
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  // I is owed the port once D has won STARVE_MAX times in a row over a waiting I.
  assign i_turn = (starve_q == SW'(STARVE_MAX));

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    i_gnt_d     = 1'b0;
    d_gnt_d     = 1'b0;
    i_rvalid_d  = 1'b0;
    d_rvalid_d  = 1'b0;
    err_d       = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.i_req && (!bus.d_req || i_turn)) begin
          state_d     = StBusyI;
          starve_d    = '0;
          i_gnt_d     = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_be_d    = '1;
          mem_addr_d  = bus.i_addr;
          mem_wdata_d = '0;
`ifdef MEM_ARB_TIMEOUT_EN
          tmo_d       = '0;
`endif
        end else if (bus.d_req) begin
          state_d     = StBusyD;
          if (bus.i_req) starve_d = starve_q + 1'b1;
          d_gnt_d     = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_be_d    = bus.d_we ? bus.d_be : '1;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
`ifdef MEM_ARB_TIMEOUT_EN
          tmo_d       = '0;
`endif
        end
      end
      StBusyI, StBusyD: begin
        if (bus.mem_ack) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          if (state_owner(state_q) == OwnerI) begin
            i_rvalid_d = 1'b1;
            i_rdata_d  = bus.mem_rdata;
          end else begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = mem_we_q ? '0 : bus.mem_rdata;
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (state_owner(state_q) == OwnerI) begin
            i_rvalid_d = 1'b1;
            i_rdata_d  = DW'(RdataErr);
          end else begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = DW'(RdataErr);
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      i_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      i_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      i_gnt_q     <= i_gnt_d;
      d_gnt_q     <= d_gnt_d;
      i_rvalid_q  <= i_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign bus.i_gnt     = i_gnt_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.i_rvalid  = i_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a memory responder and an rvalid scoreboard.
// Compiles for both settings of MEM_ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

`ifdef MEM_ARB_TIMEOUT_EN
  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(3), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`else
  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ack_delay = 0;
  bit   ack_en    = 1'b1;

  function automatic logic [31:0] model(input logic [31:0] a);
    if (a == 32'h4) return 32'h2008_0005;
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Memory responder plus completion scoreboard, both sampled 1 time unit after each edge.
  initial begin : responder
    int   wait_cnt;
    exp_t e;
    wait_cnt      = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.i_rvalid || bus.d_rvalid) begin
        if (sb.size() == 0) begin
          check("rvalid_unexpected", {bus.i_rvalid, bus.d_rvalid}, 2'b00);
        end else begin
          e = sb.pop_front();
          check("rv_owner", {bus.i_rvalid, bus.d_rvalid}, {~e.is_d, e.is_d});
          check("rv_data", bus.d_rvalid ? bus.d_rdata : bus.i_rdata, e.rdata);
          check("rv_err", bus.err, e.err);
        end
      end
      if (bus.mem_req) begin
        bus.mem_ack   = ack_en && (wait_cnt >= ack_delay);
        bus.mem_rdata = model(bus.mem_addr);
        wait_cnt++;
      end else begin
        bus.mem_ack = 1'b0;
        wait_cnt    = 0;
      end
    end
  end

  initial begin : stim
    logic [7:0]  order;
    int          ngnt;
    logic [31:0] wd;

    rst = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF;
    bus.d_addr = 32'h0; bus.d_wdata = 32'h0;

    // Reset held with both requests active: all outputs quiet.
    cyc(2);
    check("rst_ctrl", {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.err,
                       bus.mem_req, bus.mem_we, bus.mem_be}, 11'h0);
    check("rst_addr", bus.mem_addr, 32'h0);
    check("rst_wdata", bus.mem_wdata, 32'h0);
    check("rst_rdata", {bus.i_rdata, bus.d_rdata}, 64'h0);
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    rst = 1'b1;
    cyc(1);
    check("idle_after_rst", {bus.i_gnt, bus.d_gnt, bus.mem_req}, 3'b000);

    // Single fetch, ack one cycle after mem_req.
    ack_delay = 1;
    bus.i_addr = 32'h4; bus.i_req = 1'b1;
    sb.push_back('{is_d: 1'b0, rdata: 32'h2008_0005, err: 1'b0});
    cyc(1);
    check("fetch_gnt", {bus.i_gnt, bus.d_gnt, bus.mem_req}, 3'b101);
    check("fetch_addr", bus.mem_addr, 32'h4);
    check("fetch_we_be", {bus.mem_we, bus.mem_be}, 5'b01111);
    bus.i_req = 1'b0;
    cyc(1);
    check("fetch_gnt_pulse", {bus.i_gnt, bus.mem_req, bus.i_rvalid}, 3'b010);
    cyc(1);
    check("fetch_rvalid", {bus.i_rvalid, bus.mem_req}, 2'b10);
    check("fetch_rdata", bus.i_rdata, 32'h2008_0005);
    cyc(1);
    check("fetch_rdata_hold", {bus.i_rvalid, bus.i_rdata}, {1'b0, 32'h2008_0005});

    // Both requesters saturating with immediate ack: D,D,D,I,D,D,D,I.
    ack_delay = 0;
    bus.i_addr = 32'h40; bus.d_addr = 32'h80; bus.d_we = 1'b0; bus.d_be = 4'hF;
    for (int k = 0; k < 8; k++) begin
      if (k % 4 == 3) sb.push_back('{is_d: 1'b0, rdata: model(32'h40), err: 1'b0});
      else            sb.push_back('{is_d: 1'b1, rdata: model(32'h80), err: 1'b0});
    end
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    order = '0; ngnt = 0;
    for (int t = 0; t < 100 && ngnt < 8; t++) begin
      cyc(1);
      if (bus.i_gnt || bus.d_gnt) begin
        order[7 - ngnt] = bus.d_gnt;
        check("starve_addr", bus.mem_addr, bus.d_gnt ? 32'h80 : 32'h40);
        ngnt++;
      end
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    check("starve_count", ngnt, 8);
    check("starve_order", order, 8'b1110_1110);
    cyc(4);
    check("starve_drained", sb.size(), 0);

    // Store held in BUSY for five cycles before ack.
    ack_delay = 5;
    bus.d_we = 1'b1; bus.d_be = 4'b0011; bus.d_addr = 32'h100; bus.d_wdata = 32'h1234_ABCD;
    bus.d_req = 1'b1;
    sb.push_back('{is_d: 1'b1, rdata: 32'h0, err: 1'b0});
    cyc(1);
    check("store_gnt", {bus.d_gnt, bus.i_gnt, bus.mem_req}, 3'b101);
    check("store_mem", {bus.mem_we, bus.mem_be, bus.mem_addr}, {1'b1, 4'b0011, 32'h100});
    wd = 32'h1234_ABCD;
    bus.d_req = 1'b0; bus.d_wdata = 32'hFFFF_FFFF; bus.d_be = 4'hF;
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      check("store_stable", {bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_wdata, bus.d_rvalid},
            {1'b1, 1'b1, 4'b0011, wd, 1'b0});
    end
    cyc(1);
    check("store_done", {bus.d_rvalid, bus.mem_req, bus.d_rdata}, {1'b1, 1'b0, 32'h0});
    cyc(1);

    // Reset two cycles into BUSY_D: dropped without completion.
    ack_en = 1'b0;
    bus.d_we = 1'b0; bus.d_addr = 32'h200; bus.d_req = 1'b1;
    cyc(1);
    check("rstbusy_gnt", {bus.d_gnt, bus.mem_req}, 2'b11);
    bus.d_req = 1'b0;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    check("rstbusy_drop", {bus.mem_req, bus.d_rvalid, bus.d_gnt}, 3'b000);
    cyc(1);
    rst = 1'b1;
    cyc(3);
    check("rstbusy_idle", {bus.mem_req, bus.d_rvalid, bus.i_rvalid}, 3'b000);

    // Memory that never answers.
    bus.i_addr = 32'h300; bus.i_req = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
    sb.push_back('{is_d: 1'b0, rdata: 32'h0, err: 1'b1});
`endif
    cyc(1);
    check("noack_gnt", {bus.i_gnt, bus.mem_req}, 2'b11);
    bus.i_req = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int k = 1; k <= 7; k++) begin
      cyc(1);
      check("tmo_wait", {bus.mem_req, bus.err, bus.i_rvalid}, 3'b100);
    end
    cyc(1);
    check("tmo_abort", {bus.err, bus.i_rvalid, bus.mem_req, bus.i_rdata},
          {1'b1, 1'b1, 1'b0, 32'h0});
    cyc(1);
    check("tmo_err_pulse", {bus.err, bus.i_rvalid}, 2'b00);
`else
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      check("noack_hold", {bus.mem_req, bus.err, bus.i_rvalid}, 3'b100);
    end
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(1);
`endif
    ack_en = 1'b1;
    cyc(2);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
